// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {RUN, MDU_WAIT} hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= sat_inc(r_count);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline enable/flush sequencing for load-use, taken-branch and MDU hazards,
// with a saturating stall counter and a sticky MDU-timeout flag.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             ex_mdu_start,
  input  logic             mdu_done,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             mdu_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int                WAIT_W   = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MDU_TIMEOUT - 1);

  hz_state_t         r_state;
  hz_state_t         w_next_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_mdu_timeout;
  logic              w_wait_clr;
  logic              w_wait_inc;
  logic              w_timeout_set;
  logic              w_load_use;

  assign w_load_use = ex_mem_read && (ex_rd != REG_ZERO) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= RUN;
      r_wait_cnt    <= '0;
      r_mdu_timeout <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_wait_clr) begin
        r_wait_cnt <= '0;
      end else if (w_wait_inc) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end
      if (w_timeout_set) begin
        r_mdu_timeout <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_wait_clr    = 1'b0;
    w_wait_inc    = 1'b0;
    w_timeout_set = 1'b0;
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    idex_write    = 1'b1;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    exmem_bubble  = 1'b0;

    case (r_state)
      RUN: begin
        if (ex_branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (ex_mdu_start) begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_write   = 1'b0;
          exmem_bubble = 1'b1;
          w_wait_clr   = 1'b1;
          w_next_state = MDU_WAIT;
        end else if (w_load_use) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end
      end
      MDU_WAIT: begin
        if (mdu_done) begin
          w_next_state = RUN;
        end else begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_write   = 1'b0;
          exmem_bubble = 1'b1;
          // Give up on the MDU; the pipeline resumes with whatever EX holds.
          if (r_wait_cnt == WAIT_MAX) begin
            w_timeout_set = 1'b1;
            w_next_state  = RUN;
          end else begin
            w_wait_inc = 1'b1;
          end
        end
      end
      default: w_next_state = RUN;
    endcase

    if (!rst_n) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~pc_write),
    .count (stall_cycles)
  );

  assign mdu_timeout = r_mdu_timeout;

endmodule
